clk_gen_multi: RTL and testbench

CLK_GEN_MULTI -- requirements
Module: clk_gen_multi

---
 rtl/clk_gen_multi.sv | 191 +++++++++++++++++++
 tb/tb_clk_gen_multi.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : clk_gen_multi
//  Description : Multi-channel programmable clock generator. Each channel
//                produces a registered clock with independently programmable
//                high and low phase lengths (minus-one encoded). New settings
//                written to a running channel are held in a shadow register
//                and take effect at the next period boundary, so a channel
//                never emits a shortened pulse except when reset.
//                Optional build macro CLKGEN_TICK_EN adds tick_o, a one-cycle
//                strobe in the first cycle of every HIGH phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_gen_multi #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int DEF_HIGH = 49,
    parameter int DEF_LOW  = 49,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_high,
    input  logic [CNT_W-1:0]    cfg_low,
`ifdef CLKGEN_TICK_EN
    output logic [CHANNELS-1:0] tick_o,
`endif
    output logic [CHANNELS-1:0] clk_o,
    output logic [CHANNELS-1:0] pending
);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_HIGH  = 2'd1;
    localparam logic [1:0]       c_ST_LOW   = 2'd2;
    localparam logic [CNT_W-1:0] c_DEF_HIGH = CNT_W'(DEF_HIGH);
    localparam logic [CNT_W-1:0] c_DEF_LOW  = CNT_W'(DEF_LOW);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam int               c_SEL_N    = 1 << CH_W;

    // Pending flags padded to the full cfg_ch range; non-existent channels
    // read as not pending so a write to them always completes its handshake.
    logic [c_SEL_N-1:0] w_pend_sel;

    // Pad the pending vector for out-of-range channel selection
    always_comb begin
        w_pend_sel                 = '0;
        w_pend_sel[CHANNELS-1:0]   = pending;
    end

    assign cfg_ready = ~w_pend_sel[cfg_ch];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        localparam logic [CH_W-1:0] c_IDX = CH_W'(g);

        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic [CNT_W-1:0] r_act_high;
        logic [CNT_W-1:0] r_act_low;
        logic [CNT_W-1:0] r_sh_high;
        logic [CNT_W-1:0] r_sh_low;
        logic             r_pending;
        logic             r_clk;
        logic             w_clk_nxt;
        logic             w_wr;
        logic             w_boundary;
        logic             w_leave_low;
        logic             w_apply;

        // Write addressed to this channel; out-of-range cfg_ch matches no channel
        assign w_wr        = cfg_valid & cfg_ready & (cfg_ch == c_IDX);
        assign w_boundary  = (r_state == c_ST_LOW) && (r_cnt == r_act_low);
        assign w_leave_low = (r_state == c_ST_LOW) && (w_boundary || !en[g]);
        // A shadow is applied whenever the channel is not mid-period, so a
        // pending update can never be stranded while the channel idles.
        assign w_apply     = r_pending && ((r_state == c_ST_IDLE) || w_leave_low);

        // State register: FSM state, phase counter and registered outputs
        always_ff @(posedge clk_i) begin
            if (rst) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
                r_clk   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_clk   <= w_clk_nxt;
            end
        end

        // Next-state logic: phase sequencing with equality-only counter compare
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                c_ST_IDLE: begin
                    w_cnt_nxt = '0;
                    if (en[g]) begin
                        w_state_nxt = c_ST_HIGH;
                    end
                end
                c_ST_HIGH: begin
                    // The high phase always runs to completion, even if en drops
                    if (r_cnt == r_act_high) begin
                        w_state_nxt = c_ST_LOW;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                c_ST_LOW: begin
                    if (!en[g]) begin
                        w_state_nxt = c_ST_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_boundary) begin
                        w_state_nxt = c_ST_HIGH;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // Output logic: clock level follows the upcoming state
        always_comb begin
            w_clk_nxt = (w_state_nxt == c_ST_HIGH);
        end

        // Configuration registers: direct load when idle, shadowed when running
        always_ff @(posedge clk_i) begin
            if (rst) begin
                r_act_high <= c_DEF_HIGH;
                r_act_low  <= c_DEF_LOW;
                r_sh_high  <= c_DEF_HIGH;
                r_sh_low   <= c_DEF_LOW;
                r_pending  <= 1'b0;
            end else if (w_apply) begin
                // w_apply needs pending set while w_wr needs it clear, so the
                // two never coincide.
                r_act_high <= r_sh_high;
                r_act_low  <= r_sh_low;
                r_pending  <= 1'b0;
            end else if (w_wr) begin
                if (r_state == c_ST_IDLE) begin
                    r_act_high <= cfg_high;
                    r_act_low  <= cfg_low;
                end else begin
                    r_sh_high <= cfg_high;
                    r_sh_low  <= cfg_low;
                    r_pending <= 1'b1;
                end
            end
        end

        assign clk_o[g]   = r_clk;
        assign pending[g] = r_pending;

`ifdef CLKGEN_TICK_EN
        logic r_tick;
        logic w_tick_nxt;

        // Tick strobe marks the first cycle of each HIGH phase
        always_comb begin
            w_tick_nxt = (w_state_nxt == c_ST_HIGH) && (r_state != c_ST_HIGH);
        end

        // Tick register
        always_ff @(posedge clk_i) begin
            if (rst) begin
                r_tick <= 1'b0;
            end else begin
                r_tick <= w_tick_nxt;
            end
        end

        assign tick_o[g] = r_tick;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_gen_multi
//  Description : Self-checking bench for clk_gen_multi. A period-position
//                model predicts clk_o/pending/cfg_ready (and tick_o when
//                CLKGEN_TICK_EN is defined) every cycle; directed scenarios
//                add literal phase-length and handshake expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gen_multi;

    localparam int NCH  = 3;
    localparam int CW   = 16;
    localparam int DEFV = 49;

    logic            clk_i;
    logic            rst;
    logic [NCH-1:0]  en;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [1:0]      cfg_ch;
    logic [CW-1:0]   cfg_high;
    logic [CW-1:0]   cfg_low;
    logic [NCH-1:0]  clk_o;
    logic [NCH-1:0]  pending;
`ifdef CLKGEN_TICK_EN
    logic [NCH-1:0]  tick_o;
`endif

    int checks   = 0;
    int failures = 0;

    clk_gen_multi #(
        .CHANNELS (NCH),
        .CNT_W    (CW),
        .DEF_HIGH (DEFV),
        .DEF_LOW  (DEFV)
    ) dut (
        .clk_i     (clk_i),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_high  (cfg_high),
        .cfg_low   (cfg_low),
`ifdef CLKGEN_TICK_EN
        .tick_o    (tick_o),
`endif
        .clk_o     (clk_o),
        .pending   (pending)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: each running channel is described by its position within the
    // current period (0 = first high cycle). High while pos <= h, low for
    // pos in h+1 .. h+l+1, the last of which is the period boundary.
    // ------------------------------------------------------------------
    bit m_valid = 1'b0;
    int m_run [NCH];
    int m_pos [NCH];
    int m_h   [NCH];
    int m_l   [NCH];
    int m_sh  [NCH];
    int m_sl  [NCH];
    int m_pend[NCH];

    always @(posedge clk_i) begin
        if (rst) begin
            m_valid = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                m_run[c] = 0; m_pos[c] = 0; m_pend[c] = 0;
                m_h[c] = DEFV; m_l[c] = DEFV;
            end
        end else if (m_valid) begin
            for (int c = 0; c < NCH; c++) begin
                bit in_low, leave_low, apply, acc, was_run;
                was_run   = (m_run[c] != 0);
                in_low    = was_run && (m_pos[c] > m_h[c]);
                leave_low = in_low && (!en[c] || (m_pos[c] == m_h[c] + m_l[c] + 1));
                apply     = (m_pend[c] != 0) && (!was_run || leave_low);
                acc       = cfg_valid && (int'(cfg_ch) == c) && (m_pend[c] == 0);
                if (!was_run) begin
                    if (en[c]) begin m_run[c] = 1; m_pos[c] = 0; end
                end else if (!in_low) begin
                    m_pos[c]++;
                end else if (!en[c]) begin
                    m_run[c] = 0; m_pos[c] = 0;
                end else if (m_pos[c] == m_h[c] + m_l[c] + 1) begin
                    m_pos[c] = 0;
                end else begin
                    m_pos[c]++;
                end
                if (apply) begin
                    m_h[c] = m_sh[c]; m_l[c] = m_sl[c]; m_pend[c] = 0;
                end else if (acc) begin
                    if (!was_run) begin
                        m_h[c] = int'(cfg_high); m_l[c] = int'(cfg_low);
                    end else begin
                        m_sh[c] = int'(cfg_high); m_sl[c] = int'(cfg_low); m_pend[c] = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(posedge clk_i) begin
        #2;
        if (m_valid) begin
            for (int c = 0; c < NCH; c++) begin
                chk($sformatf("clk_o[%0d]", c), 32'(clk_o[c]),
                    32'((m_run[c] != 0) && (m_pos[c] <= m_h[c])));
                chk($sformatf("pending[%0d]", c), 32'(pending[c]), 32'(m_pend[c] != 0));
`ifdef CLKGEN_TICK_EN
                chk($sformatf("tick_o[%0d]", c), 32'(tick_o[c]),
                    32'((m_run[c] != 0) && (m_pos[c] == 0)));
`endif
            end
            chk("cfg_ready", 32'(cfg_ready),
                32'((int'(cfg_ch) >= NCH) ? 1 : (m_pend[int'(cfg_ch)] == 0)));
        end
    end

    // Count consecutive cycles (sampled on negedge) that clk_o[ch] sits at lvl
    task automatic run_len(input int ch, input logic lvl, output int n);
        n = 0;
        while (clk_o[ch] === lvl && n < 1000) begin
            n++;
            @(negedge clk_i);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input int hi, input int lo);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_high = CW'(hi); cfg_low = CW'(lo);
        @(negedge clk_i);
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n, hi, lo, k, ticks, bad;
        logic prev;
        rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_high = '0; cfg_low = '0;
        repeat (3) @(negedge clk_i);
        rst = 1'b0;
        @(negedge clk_i);
        chk("reset_clk_o", 32'(clk_o), 0);
        chk("reset_pending", 32'(pending), 0);
        chk("reset_cfg_ready", 32'(cfg_ready), 1);

        // Defaults: 50 high / 50 low, first high one cycle after en
        en = 3'b001;
        @(negedge clk_i);
        chk("first_high_ch0", 32'(clk_o[0]), 1);
        run_len(0, 1'b1, hi);
        run_len(0, 1'b0, lo);
        chk("def_high_len", hi, 50);
        chk("def_low_len", lo, 50);
        chk("def_period", hi + lo, 100);

        // Mid-HIGH write to running ch0: shadowed until the boundary
        repeat (5) @(negedge clk_i);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_high = 16'd1; cfg_low = 16'd2;
        #1 chk("ready_before_write", 32'(cfg_ready), 1);
        @(negedge clk_i);
        cfg_valid = 1'b0;
        chk("pending0_set", 32'(pending[0]), 1);
        chk("ready0_blocked", 32'(cfg_ready), 0);
        cfg_write(2'd0, 7, 7);  // refused: ch0 still pending
        k = 0;
        while (pending[0] === 1'b1 && k < 300) begin k++; @(negedge clk_i); end
        chk("pending0_cleared", 32'(pending[0]), 0);
        chk("new_period_starts_high", 32'(clk_o[0]), 1);
        run_len(0, 1'b1, hi);
        run_len(0, 1'b0, lo);
        chk("ch0_new_high", hi, 2);
        chk("ch0_new_low", lo, 3);
        run_len(0, 1'b1, hi);
        chk("ch0_new_high_again", hi, 2);

        // Idle ch1 written 0/0 directly, then enabled: divide by two
        cfg_write(2'd1, 0, 0);
        chk("pending1_idle_write", 32'(pending[1]), 0);
        en = 3'b011;
        @(negedge clk_i);
        chk("first_high_ch1", 32'(clk_o[1]), 1);
        run_len(1, 1'b1, hi);
        run_len(1, 1'b0, lo);
        chk("ch1_high", hi, 1);
        chk("ch1_low", lo, 1);
        run_len(1, 1'b1, hi);
        chk("ch1_high_again", hi, 1);

        // ch2: en dropped 3 cycles into a 50-cycle high, no runt
        en = 3'b111;
        @(negedge clk_i);
        n = 0;
        while (clk_o[2] === 1'b1 && n < 1000) begin
            n++;
            if (n == 3) en[2] = 1'b0;
            @(negedge clk_i);
        end
        chk("ch2_full_high_after_en_drop", n, 50);
        k = 0;
        repeat (60) begin
            if (clk_o[2] !== 1'b0) k++;
            @(negedge clk_i);
        end
        chk("ch2_stays_idle", k, 0);

        // Out-of-range channel: handshake completes, nothing changes
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_high = 16'd5; cfg_low = 16'd5;
        #1 chk("ready_out_of_range", 32'(cfg_ready), 1);
        @(negedge clk_i);
        cfg_valid = 1'b0;
        chk("pending_out_of_range", 32'(pending), 0);

        // Reset mid-HIGH with pending on every channel
        en = 3'b000;
        repeat (10) @(negedge clk_i);
        chk("all_idle", 32'(clk_o), 0);
        cfg_write(2'd0, 20, 20);
        cfg_write(2'd1, 20, 20);
        cfg_write(2'd2, 20, 20);
        en = 3'b111;
        repeat (5) @(negedge clk_i);
        cfg_write(2'd0, 9, 9);
        cfg_write(2'd1, 9, 9);
        cfg_write(2'd2, 9, 9);
        chk("all_pending", 32'(pending), 32'h7);
        chk("all_high_before_rst", 32'(clk_o), 32'h7);
        rst = 1'b1;
        @(negedge clk_i);
        chk("rst_clk_o_low", 32'(clk_o), 0);
        chk("rst_pending_clear", 32'(pending), 0);
        rst = 1'b0;
        @(negedge clk_i);
        chk("restart_all_high", 32'(clk_o), 32'h7);
        run_len(2, 1'b1, hi);
        chk("post_rst_def_high", hi, 50);

`ifdef CLKGEN_TICK_EN
        // Tick strobe with 2-high/3-low: one pulse per 5 cycles at each rise
        en = 3'b000;
        repeat (60) @(negedge clk_i);
        cfg_write(2'd0, 1, 2);
        en = 3'b001;
        prev = 1'b0; ticks = 0; bad = 0;
        repeat (25) begin
            @(negedge clk_i);
            if (tick_o[0] === 1'b1) ticks++;
            if (tick_o[0] !== (clk_o[0] & ~prev)) bad++;
            prev = clk_o[0];
        end
        chk("tick_count", ticks, 5);
        chk("tick_aligned", bad, 0);
`endif

        repeat (5) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
